// File: rtl/alu_pkg.sv
// Shared ALU constants and types for the issue/writeback stage.
// Func codes follow the lab4 ALU encoding.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int FUNC_W = 5;

   // Shift and mul/div are families; only the prefix bits are fixed.
   localparam logic [FUNC_W-1:0] FUNC_SHIFT  = 5'b00000;
   localparam logic [FUNC_W-1:0] FUNC_MULDIV = 5'b10000;
   localparam logic [FUNC_W-1:0] FUNC_ADD    = 5'b10110;
   localparam logic [FUNC_W-1:0] FUNC_SUB    = 5'b10111;
   localparam logic [FUNC_W-1:0] FUNC_AND    = 5'b11000;
   localparam logic [FUNC_W-1:0] FUNC_OR     = 5'b11001;
   localparam logic [FUNC_W-1:0] FUNC_NOR    = 5'b11010;
   localparam logic [FUNC_W-1:0] FUNC_XOR    = 5'b11011;

   typedef struct packed {
      logic              valid;
      logic              load;
      logic [FUNC_W-1:0] func;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] imm;
   } e_op_t;

   function automatic logic is_addsub(input logic [FUNC_W-1:0] f);
      return f[4:1] == FUNC_ADD[4:1];
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: one write port, three combinational read ports.
// Register 0 is never written and always reads as zero.
import alu_pkg::*;

module alu_regfile #(
   parameter int NREGS  = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] rs_addr,
   output logic [DATA_W-1:0] rs_data,
   input  logic [REG_AW-1:0] rt_addr,
   output logic [DATA_W-1:0] rt_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
   assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_regfile_stage.sv
// Issue/writeback stage around the external combinational ALU.
// One op per cycle; results forwarded from E so dependents never wait.
import alu_pkg::*;

module alu_regfile_stage #(
   parameter int NREGS  = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_load,
   input  logic [4:0]        in_func,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [31:0]       in_imm,
   input  logic              stall,
   output logic [31:0]       alu_A,
   output logic [31:0]       alu_B,
   output logic [4:0]        alu_func,
   input  logic [31:0]       alu_result,
   input  logic              alu_overflow,
   input  logic              alu_zero,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic [31:0]       wb_data,
   output logic              flag_zero,
   output logic              flag_ovf,
   input  logic              flag_clr,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [31:0]       dbg_data
);

   e_op_t             e_op;
   logic [REG_AW-1:0] e_rd;
   logic [DATA_W-1:0] e_value;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;
   logic              retire;
   logic              ovf_set;
   logic              issue;

   assign in_ready = ~stall;
   assign issue    = in_valid & ~stall;
   assign retire   = e_op.valid & ~stall;
   assign e_value  = e_op.load ? e_op.imm : alu_result;

   // Only add/sub produce a meaningful overflow from the ALU.
   assign ovf_set  = retire & ~e_op.load & alu_overflow
                   & is_addsub(e_op.func);

   assign alu_A    = e_op.a;
   assign alu_B    = e_op.b;
   assign alu_func = e_op.func;

   alu_regfile #(
      .NREGS  (NREGS),
      .REG_AW (REG_AW)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we       (retire),
      .waddr    (e_rd),
      .wdata    (e_value),
      .rs_addr  (in_rs),
      .rs_data  (rs_data),
      .rt_addr  (in_rt),
      .rt_data  (rt_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Forward the in-flight E result; r0 never forwards.
   always_comb begin
      fwd_a = rs_data;
      if (in_rs == '0) begin
         fwd_a = '0;
      end else if (e_op.valid && e_rd == in_rs) begin
         fwd_a = e_value;
      end
   end

   always_comb begin
      fwd_b = rt_data;
      if (in_rt == '0) begin
         fwd_b = '0;
      end else if (e_op.valid && e_rd == in_rt) begin
         fwd_b = e_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_op <= '0;
         e_rd <= '0;
      end else if (!stall) begin
         e_op.valid <= in_valid;
         if (issue) begin
            e_op.load <= in_load;
            e_op.func <= in_func;
            e_op.a    <= fwd_a;
            e_op.b    <= fwd_b;
            e_op.imm  <= in_imm;
            e_rd      <= in_rd;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         flag_zero <= 1'b0;
      end else begin
         wb_valid <= retire;
         if (retire) begin
            wb_rd     <= e_rd;
            wb_data   <= e_value;
            flag_zero <= e_op.load ? (e_op.imm == '0) : alu_zero;
         end
      end
   end

   // A same-edge set beats the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_ovf <= 1'b0;
      end else if (ovf_set) begin
         flag_ovf <= 1'b1;
      end else if (flag_clr && !stall) begin
         flag_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_regfile_stage.sv
// Bench for alu_regfile_stage: directed scenarios plus random ops
// checked against an in-order architectural model.
module tb_alu_regfile_stage;

   logic        clk = 0;
   logic        rst;
   logic        in_valid, in_ready, in_load;
   logic [4:0]  in_func;
   logic [2:0]  in_rs, in_rt, in_rd;
   logic [31:0] in_imm;
   logic        stall;
   logic [31:0] alu_A, alu_B, alu_result;
   logic [4:0]  alu_func;
   logic        alu_overflow, alu_zero;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flag_zero, flag_ovf, flag_clr;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   int checks = 0;
   int errors = 0;

   alu_regfile_stage #(.NREGS(8), .REG_AW(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_load(in_load), .in_func(in_func),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .stall(stall),
      .alu_A(alu_A), .alu_B(alu_B), .alu_func(alu_func),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flag_zero(flag_zero), .flag_ovf(flag_ovf),
      .flag_clr(flag_clr),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Lab4 ALU behaviour; overflow is junk for non add/sub ops.
   function automatic logic [32:0] alu_f(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [4:0] f);
      logic [31:0] r;
      logic o;
      o = a[31] ^ b[31];
      case (f)
         5'b10110: begin
            r = a + b;
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'b10111: begin
            r = a - b;
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         5'b11000: r = a & b;
         5'b11001: r = a | b;
         5'b11010: r = ~(a | b);
         5'b11011: r = a ^ b;
         default:  r = f[4] ? a * b : a << b[4:0];
      endcase
      return {o, r};
   endfunction

   always_comb begin
      {alu_overflow, alu_result} = alu_f(alu_A, alu_B, alu_func);
      alu_zero = (alu_result == 32'd0);
   end

   // Architectural model: ops execute in program order at issue.
   logic [31:0] m_regs [8];
   logic        m_zero, m_ovf;
   logic        p_valid, p_zero, p_set;
   logic [2:0]  p_rd;
   logic [31:0] p_data, p_a, p_b;
   logic [4:0]  p_func;
   logic        exp_wbv;
   logic [2:0]  exp_rd;
   logic [31:0] exp_data;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_zero = 0; m_ovf = 0; p_valid = 0; exp_wbv = 0;
   endtask

   task automatic step(input logic v, input logic ld,
                       input logic [4:0] f, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd,
                       input logic [31:0] imm, input logic stl,
                       input logic clr);
      logic [32:0] res;
      in_valid = v; in_load = ld; in_func = f;
      in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
      stall = stl; flag_clr = clr;
      @(posedge clk);
      #1;
      exp_wbv = 0;
      if (!stl) begin
         exp_wbv = p_valid;
         if (p_valid) begin
            exp_rd = p_rd; exp_data = p_data; m_zero = p_zero;
         end
         if (p_valid && p_set) m_ovf = 1;
         else if (clr) m_ovf = 0;
         p_valid = v;
         if (v) begin
            p_a = m_regs[rs]; p_b = m_regs[rt]; p_func = f;
            res = alu_f(p_a, p_b, f);
            p_data = ld ? imm : res[31:0];
            p_zero = (p_data == 0);
            p_set = !ld && res[32] && (f[4:1] == 4'b1011);
            p_rd = rd;
            if (rd != 0) m_regs[rd] = p_data;
         end
      end
   endtask

   task automatic idle(input logic clr);
      step(0, 0, 0, 0, 0, 0, 0, 0, clr);
   endtask

   task automatic ld(input logic [2:0] rd, input logic [31:0] imm);
      step(1, 1, 5'b10110, 0, 0, rd, imm, 0, 0);
   endtask

   task automatic op(input logic [4:0] f, input logic [2:0] rd,
                     input logic [2:0] rs, input logic [2:0] rt);
      step(1, 0, f, rs, rt, rd, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 0; in_load = 0; in_func = 0;
      in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
      stall = 0; flag_clr = 0; dbg_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wb_valid, wb_rd, wb_data, flag_zero, flag_ovf} !== 0 ||
          {alu_A, alu_B, alu_func} !== 0 || in_ready !== 1) begin
         errors++;
         $display("FAIL reset: wbv=%b A=%h B=%h f=%h ovf=%b rdy=%b",
                  wb_valid, alu_A, alu_B, alu_func, flag_ovf, in_ready);
      end
      @(negedge clk);
      rst = 0;
      #1;
   endtask

   task automatic test_load_dbg();
      ld(1, 5);
      ld(2, 3);
      checks++;
      if (wb_valid !== 1 || wb_rd !== 1 || wb_data !== 5) begin
         errors++;
         $display("FAIL load_r1: got %b/%0d/%h want 1/1/5",
                  wb_valid, wb_rd, wb_data);
      end
      idle(0);
      checks++;
      if (wb_valid !== 1 || wb_rd !== 2 || wb_data !== 3) begin
         errors++;
         $display("FAIL load_r2: got %b/%0d/%h want 1/2/3",
                  wb_valid, wb_rd, wb_data);
      end
      idle(0);
      dbg_addr = 1;
      #1;
      checks++;
      if (wb_valid !== 0 || dbg_data !== 5) begin
         errors++;
         $display("FAIL dbg_r1: wbv=%b dbg=%h want 0/5",
                  wb_valid, dbg_data);
      end
   endtask

   task automatic test_forward();
      op(5'b10110, 3, 1, 2);
      op(5'b11011, 4, 3, 1);
      checks++;
      if (wb_valid !== 1 || wb_rd !== 3 || wb_data !== 8) begin
         errors++;
         $display("FAIL fwd_add: got %b/%0d/%h want 1/3/8",
                  wb_valid, wb_rd, wb_data);
      end
      idle(0);
      checks++;
      if (wb_valid !== 1 || wb_rd !== 4 || wb_data !== 13) begin
         errors++;
         $display("FAIL fwd_xor: got %b/%0d/%h want 1/4/d",
                  wb_valid, wb_rd, wb_data);
      end
   endtask

   task automatic test_overflow();
      ld(1, 32'h7FFF_FFFF);
      ld(2, 1);
      op(5'b10110, 3, 1, 2);
      op(5'b11000, 4, 1, 2);
      checks++;
      if (flag_ovf !== 1 || wb_data !== 32'h8000_0000) begin
         errors++;
         $display("FAIL ovf_set: ovf=%b d=%h want 1/80000000",
                  flag_ovf, wb_data);
      end
      idle(0);
      checks++;
      if (flag_ovf !== 1 || wb_data !== 1) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b d=%h want 1/1",
                  flag_ovf, wb_data);
      end
      idle(1);
      checks++;
      if (flag_ovf !== 0) begin
         errors++;
         $display("FAIL ovf_clr: ovf=%b want 0", flag_ovf);
      end
      op(5'b10110, 5, 1, 2);
      idle(1);
      checks++;
      if (flag_ovf !== 1 || wb_rd !== 5) begin
         errors++;
         $display("FAIL ovf_set_wins: ovf=%b rd=%0d want 1/5",
                  flag_ovf, wb_rd);
      end
      idle(1);
   endtask

   task automatic test_zero();
      ld(5, 32'hF0);
      ld(6, 32'h0F);
      op(5'b11000, 7, 5, 6);
      op(5'b11001, 7, 5, 6);
      checks++;
      if (wb_rd !== 7 || wb_data !== 0 || flag_zero !== 1) begin
         errors++;
         $display("FAIL zero_and: rd=%0d d=%h z=%b want 7/0/1",
                  wb_rd, wb_data, flag_zero);
      end
      idle(0);
      checks++;
      if (wb_rd !== 7 || wb_data !== 32'hFF || flag_zero !== 0) begin
         errors++;
         $display("FAIL zero_or: rd=%0d d=%h z=%b want 7/ff/0",
                  wb_rd, wb_data, flag_zero);
      end
   endtask

   task automatic test_stall();
      op(5'b10110, 3, 5, 6);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 5'b10111, 1, 2, 4, 0, 1, 0);
         checks++;
         if (in_ready !== 0 || wb_valid !== 0 ||
             alu_A !== 32'hF0 || alu_B !== 32'h0F ||
             alu_func !== 5'b10110) begin
            errors++;
            $display("FAIL stall_hold: rdy=%b wbv=%b A=%h B=%h f=%b",
                     in_ready, wb_valid, alu_A, alu_B, alu_func);
         end
      end
      idle(0);
      checks++;
      if (wb_valid !== 1 || wb_rd !== 3 || wb_data !== 32'hFF) begin
         errors++;
         $display("FAIL stall_release: got %b/%0d/%h want 1/3/ff",
                  wb_valid, wb_rd, wb_data);
      end
      idle(0);
      checks++;
      if (wb_valid !== 0) begin
         errors++;
         $display("FAIL stall_single_wb: wbv=%b want 0", wb_valid);
      end
   endtask

   task automatic test_r0();
      ld(0, 32'hDEAD);
      op(5'b10110, 1, 0, 0);
      checks++;
      if (wb_valid !== 1 || wb_rd !== 0 || wb_data !== 32'hDEAD ||
          flag_zero !== 0) begin
         errors++;
         $display("FAIL r0_wb: got %b/%0d/%h z=%b want 1/0/dead/0",
                  wb_valid, wb_rd, wb_data, flag_zero);
      end
      idle(0);
      dbg_addr = 0;
      #1;
      checks++;
      if (wb_data !== 0 || wb_rd !== 1 || flag_zero !== 1 ||
          dbg_data !== 0) begin
         errors++;
         $display("FAIL r0_read: d=%h rd=%0d z=%b dbg=%h want 0/1/1/0",
                  wb_data, wb_rd, flag_zero, dbg_data);
      end
   endtask

   task automatic test_random();
      logic [4:0] ops [6];
      logic [4:0] f;
      logic [31:0] imm;
      ops = '{5'b10110, 5'b10111, 5'b11000,
              5'b11001, 5'b11010, 5'b11011};
      for (int n = 0; n < 300; n++) begin
         f = ($urandom_range(3) == 0) ? 5'($urandom)
                                      : ops[$urandom_range(5)];
         case ($urandom_range(3))
            0: imm = 0;
            1: imm = $urandom_range(1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: imm = $urandom;
         endcase
         step($urandom_range(4) != 0, $urandom_range(2) == 0, f,
              3'($urandom), 3'($urandom), 3'($urandom), imm,
              $urandom_range(7) == 0, $urandom_range(7) == 0);
         checks++;
         if (wb_valid !== exp_wbv || flag_zero !== m_zero ||
             flag_ovf !== m_ovf || in_ready !== ~stall ||
             (exp_wbv && (wb_rd !== exp_rd || wb_data !== exp_data)) ||
             (p_valid && (alu_A !== p_a || alu_B !== p_b ||
                          alu_func !== p_func))) begin
            errors++;
            $display("FAIL rand[%0d]: wb %b/%0d/%h z%b o%b A%h B%h f%b",
                     n, wb_valid, wb_rd, wb_data, flag_zero,
                     flag_ovf, alu_A, alu_B, alu_func);
            $display("  want wb %b/%0d/%h z%b o%b A%h B%h f%b",
                     exp_wbv, exp_rd, exp_data, m_zero, m_ovf,
                     p_a, p_b, p_func);
         end
      end
      idle(0);
      idle(0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         checks++;
         if (dbg_data !== m_regs[i]) begin
            errors++;
            $display("FAIL rand_dbg r%0d: got %h want %h",
                     i, dbg_data, m_regs[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      ld(5, 32'h1234);
      ld(6, 32'h5678);
      rst = 1;
      #1;
      checks++;
      if (wb_valid !== 0 || alu_A !== 0 || alu_func !== 0 ||
          flag_ovf !== 0 || flag_zero !== 0) begin
         errors++;
         $display("FAIL rst_mid: wbv=%b A=%h f=%b ovf=%b z=%b",
                  wb_valid, alu_A, alu_func, flag_ovf, flag_zero);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         checks++;
         if (dbg_data !== 0) begin
            errors++;
            $display("FAIL rst_mid_reg r%0d: got %h want 0",
                     i, dbg_data);
         end
      end
      in_valid = 0;
      @(negedge clk);
      rst = 0;
      model_reset();
      idle(0);
      checks++;
      if (wb_valid !== 0) begin
         errors++;
         $display("FAIL rst_mid_nowb: wbv=%b want 0", wb_valid);
      end
   endtask

   initial begin
      test_reset();
      test_load_dbg();
      test_forward();
      test_overflow();
      test_zero();
      test_stall();
      test_r0();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_regfile_stage.md
Name: alu_regfile_stage

Overview:
- Issue/writeback stage wrapped around the combinational lab4 ALU.
- Holds a small register file and accepts one instruction per cycle over a valid/ready handshake.
- Registers operands A/B and func into an execute (E) register that drives the ALU, then writes the ALU result back into the register file at the end of E.
- Provides RAW forwarding from E, an immediate-load path that bypasses the ALU, status flags, and a debug read port.

Parameters:
- NREGS, 8, number of 32-bit registers; must be a power of two.
- REG_AW, 3, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts an instruction this cycle; equals ~stall.
- in_load  in  1  1 = write in_imm to rd without using the ALU; 0 = ALU op.
- in_func  in  5  ALU function code, passed through unchanged.
- in_rs  in  REG_AW  source register for A.
- in_rt  in  REG_AW  source register for B.
- in_rd  in  REG_AW  destination register.
- in_imm  in  32  immediate, used only when in_load=1.
- stall  in  1  freezes the E register and inhibits writeback.
- alu_A  out  32  E-register operand A to the ALU.
- alu_B  out  32  E-register operand B to the ALU.
- alu_func  out  5  E-register func to the ALU.
- alu_result  in  32  ALU result, combinational from alu_A/alu_B/alu_func.
- alu_overflow  in  1  ALU overflow.
- alu_zero  in  1  ALU zero flag.
- wb_valid  out  1  one-cycle pulse: a write retired at this edge.
- wb_rd  out  REG_AW  register written.
- wb_data  out  32  value written.
- flag_zero  out  1  zero flag of the last retired op.
- flag_ovf  out  1  sticky overflow.
- flag_clr  in  1  clears flag_ovf.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  32  regfile[dbg_addr], combinational, no forwarding.

Behaviour:
Reset (asynchronous):
- All registers reset to 0; E_valid=0.
- alu_A, alu_B, alu_func, wb_* and flags all reset to 0.

Register 0:
- Always reads 0; writes to it are discarded.
- A retiring op with rd=0 still pulses wb_valid with wb_rd=0, and still updates the flags.

Issue:
- On a rising edge with in_valid & in_ready, the E register loads:
  - A = fwd(rs), B = fwd(rt), func, rd, load, imm;
  - E_valid=1.
- If in_valid=0 and stall=0, E_valid goes to 0.

Forwarding:
- fwd(r) returns 0 if r=0.
- Otherwise, if E_valid & E_rd==r, it returns E_value, where E_value = E_load ? E_imm : alu_result.
- Otherwise it returns regfile[r].

Retire (each edge with E_valid & ~stall):
- regfile[E_rd] <= E_value (unless E_rd=0).
- wb_valid=1, wb_rd=E_rd, wb_data=E_value, all registered.
- Otherwise wb_valid=0.

Latency:
- Instruction accepted at edge N retires at edge N+1.
- Back-to-back dependent ops run at full rate via forwarding; no bubbles.

Stall:
- The E register, regfile and flags hold.
- in_ready=0.
- alu_A/B/func stay stable.
- wb_valid=0.

Flags (on retire only):
- flag_zero <= E_load ? (E_imm==0) : alu_zero.
- flag_ovf is set when ~E_load & alu_overflow & (E_func[4:1]==4'b1011); the ALU overflow output is meaningful only for add/sub.
- flag_clr clears flag_ovf. If clr and set occur in the same edge, set wins.

Loads:
- alu_func is still driven with E_func, but alu_result is ignored.

Simultaneous write/read:
- The regfile read for issue uses forwarding, so a same-edge retire to rs is never missed.
- dbg_data shows the old value until the edge.

Reset mid-operation:
- The in-flight E op is dropped.
- No writeback occurs.

Decomposition:
- Shared package alu_pkg holds:
  - ALU func constants: FUNC_SHIFT 5'b00???, FUNC_MULDIV 5'b100??, FUNC_ADD 5'b10110, FUNC_SUB 5'b10111, FUNC_AND 5'b11000, FUNC_OR 5'b11001, FUNC_NOR 5'b11010, FUNC_XOR 5'b11011.
  - The width constants DATA_W=32 and FUNC_W=5.
- One sub-module, alu_regfile (NREGS x 32, one write port, three combinational read ports: rs, rt, dbg; r0 hardwired to 0), instanced once.
- Forwarding, the E register and the flags live in the top.

Test Plan:
- Reset then load r1=5, r2=3 -> wb pulses (1,5),(2,3); dbg_addr=1 -> dbg_data=5.
- Issue ADD r3=r1+r2, then immediately XOR r4=r3^r1 -> wb (3,8) then (4,13) via forwarding, no bubble.
- Load r1=0x7FFFFFFF, r2=1, ADD r3 -> flag_ovf=1 and stays 1 across a following AND; flag_clr -> 0; clr and overflow in the same cycle -> stays 1.
- Load r5=0xF0, r6=0x0F, AND r7 -> wb_data=0 and flag_zero=1; then OR r7 -> 0xFF and flag_zero=0.
- Assert stall for 3 cycles with an ALU op in E -> alu_A/B/func stable, in_ready=0, no wb; release -> single wb with the correct value.
- Write to r0 with imm=0xDEAD -> wb_valid=1, but reads of r0 and dbg r0 return 0; assert rst mid-op with E_valid=1 -> no wb and all registers 0.
